mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, byte address width.
REQ-002 SHALL have parameter DATA_W, default 32, word width.
REQ-003 SHALL have parameter MEM_BYTES, default 1024, size of the backing memory in bytes.
REQ-004 SHALL have port clk  input  1  the single clock; all state updates on posedge clk.
REQ-005 SHALL have port rst_n  input  1  reset; synchronous, active-low.
REQ-006 SHALL have ports if_req in 1, if_addr in ADDR_W; if_ack out 1, if_rdata out DATA_W, if_err out 1 (instruction port, read-only).
REQ-007 SHALL have ports d_req in 1, d_we in 1, d_addr in ADDR_W, d_wdata in DATA_W; d_ack out 1, d_rdata out DATA_W, d_err out 1 (data port).
REQ-008 SHALL have ports mem_addr out ADDR_W, mem_wdata out DATA_W, mem_rd out 1, mem_wr out 1, mem_rdata in DATA_W (shared memory side).

Function
REQ-009 SHALL implement FSM IDLE -> ACCESS -> RESP -> IDLE; it is never in ACCESS or RESP without a latched grant.
REQ-010 In IDLE with at least one req high, SHALL latch the grant, address, we and wdata at the clock edge and go to ACCESS.
REQ-011 In ACCESS, SHALL drive mem_addr from the latched address and pulse mem_rd (read) or mem_wr (write) for exactly one cycle.
REQ-012 In RESP, SHALL capture mem_rdata into the granted port's rdata and assert that port's ack for exactly one cycle.
REQ-013 Fixed latency: req sampled at edge N gives ACCESS in cycle N+1 and ack in cycle N+2; at most one transaction per 3 cycles.
REQ-014 The ungranted port's ack SHALL stay 0; its rdata SHALL hold its last value.
REQ-015 A requester SHALL hold req until it sees ack. A req still high in the IDLE cycle after RESP SHALL start a new transaction.
REQ-016 Fault: addr[1:0] != 0, or addr > MEM_BYTES-4, SHALL suppress mem_rd/mem_wr in ACCESS and give ack with err=1 and rdata=0 at the same latency.
REQ-017 err SHALL be 0 on every non-faulting ack.
REQ-018 mem_rd and mem_wr SHALL never be high in the same cycle, and never outside ACCESS.
REQ-019 A write ack SHALL report rdata = 0; the memory captures mem_wdata at the edge that ends the ACCESS cycle.

Reset
REQ-020 rst_n low at a clock edge SHALL force IDLE and clear if_ack, d_ack, if_err, d_err, mem_rd, mem_wr, if_rdata, d_rdata, mem_addr, mem_wdata and last_grant (= instruction port) from the next cycle.
REQ-021 Reset during ACCESS or RESP SHALL drop the transaction: no ack, and no strobe in the cycle after reset.

Configuration
REQ-022 With macro MEM_ARB_RR_EN defined, simultaneous requests SHALL alternate grants; the port not granted last wins, so after reset the data port wins first.
REQ-023 Without MEM_ARB_RR_EN, the data port SHALL always win simultaneous requests (fixed priority), and last_grant SHALL not be implemented.
REQ-024 A lone request SHALL be granted immediately in both configurations.

Structure
REQ-025 FSM state encodings, port IDs (PORT_IF=0, PORT_D=1) and the alignment mask SHALL live in a shared definitions package/header with an include guard.
REQ-026 Grant selection SHALL be the one sub-module, arb_pick (inputs if_req, d_req, last_grant; output grant); it is purely combinational.

Verification
REQ-027 if_req=1, if_addr=8, mem holds 0x11223344 at byte 8 -> mem_rd high in cycle N+1 only, if_ack high in cycle N+2, if_rdata=0x11223344, if_err=0.
REQ-028 d_req=1, d_we=1, d_addr=16, d_wdata=0xDEADBEEF, then a d read of 16 -> mem_wr pulses once, both acks err=0, read returns 0xDEADBEEF.
REQ-029 if_req and d_req both held high for 4 transactions -> RR_EN grant order D,IF,D,IF; without the macro, D,D,D,D with if_ack never high.
REQ-030 d_addr=6 read; separately d_addr=1024 write -> no mem_rd/mem_wr, d_ack with d_err=1 and d_rdata=0 at N+2.
REQ-031 rst_n low in the ACCESS cycle of a write to addr 20 -> no ack; FSM in IDLE next cycle; all outputs 0; memory word 20 is written at most once.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for mem_arbiter: FSM states, port IDs and word-alignment mask.
`ifndef MEM_ARBITER_PKG_SV
`define MEM_ARBITER_PKG_SV
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

    localparam logic PORT_IF = 1'b0;
    localparam logic PORT_D  = 1'b1;

    localparam logic [1:0] ALIGN_MASK = 2'b11;

endpackage
`endif

// File: rtl/mem_arbiter_arb_pick.sv
// Combinational grant selection; MEM_ARB_RR_EN selects round-robin, otherwise data port has fixed priority.
module arb_pick
    import mem_arbiter_pkg::*;
(
    input  logic if_req,
    input  logic d_req,
    input  logic last_grant,
    output logic grant
);

    always_comb begin
        grant = last_grant;
`ifdef MEM_ARB_RR_EN
        if (if_req && d_req) begin
            grant = (last_grant == PORT_IF) ? PORT_D : PORT_IF;
        end else if (d_req) begin
            grant = PORT_D;
        end else if (if_req) begin
            grant = PORT_IF;
        end
`else
        if (d_req) begin
            grant = PORT_D;
        end else if (if_req) begin
            grant = PORT_IF;
        end
`endif
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (instruction/data) arbiter onto one memory with a fixed 3-cycle IDLE/ACCESS/RESP sequence.
// Optional macro MEM_ARB_RR_EN enables round-robin arbitration between simultaneous requests.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MEM_BYTES = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_err,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_rd,
    output logic              mem_wr,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [ADDR_W-1:0] MAX_ADDR = ADDR_W'(MEM_BYTES - 4);

    state_e            state_q, state_d;
    logic              grant_q, grant_d;
    logic              we_q, we_d;
    logic              fault_q, fault_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              mem_rd_q, mem_rd_d;
    logic              mem_wr_q, mem_wr_d;
    logic              if_ack_q, if_ack_d;
    logic              d_ack_q, d_ack_d;
    logic              if_err_q, if_err_d;
    logic              d_err_q, d_err_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              pick;
    logic              last_grant;
    logic [ADDR_W-1:0] sel_addr;
    logic              sel_we;
    logic              sel_fault;
    logic [DATA_W-1:0] resp_data;

`ifdef MEM_ARB_RR_EN
    logic last_grant_q, last_grant_d;
    assign last_grant = last_grant_q;
`else
    assign last_grant = PORT_IF;
`endif

    arb_pick u_arb_pick (
        .if_req     (if_req),
        .d_req      (d_req),
        .last_grant (last_grant),
        .grant      (pick)
    );

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        we_d        = we_q;
        fault_d     = fault_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_rd_d    = 1'b0;
        mem_wr_d    = 1'b0;
        if_ack_d    = 1'b0;
        d_ack_d     = 1'b0;
        if_err_d    = 1'b0;
        d_err_d     = 1'b0;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        sel_addr    = (pick == PORT_D) ? d_addr : if_addr;
        sel_we      = (pick == PORT_D) && d_we;
        sel_fault   = ((sel_addr[1:0] & ALIGN_MASK) != 2'b00) || (sel_addr > MAX_ADDR);
        resp_data   = (fault_q || we_q) ? '0 : mem_rdata;
`ifdef MEM_ARB_RR_EN
        last_grant_d = last_grant_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (if_req || d_req) begin
                    state_d     = ST_ACCESS;
                    grant_d     = pick;
                    we_d        = sel_we;
                    fault_d     = sel_fault;
                    mem_addr_d  = sel_addr;
                    mem_wdata_d = (pick == PORT_D) ? d_wdata : '0;
                    // Strobes are registered, so they appear exactly in the ACCESS cycle.
                    mem_rd_d    = !sel_fault && !sel_we;
                    mem_wr_d    = !sel_fault && sel_we;
`ifdef MEM_ARB_RR_EN
                    last_grant_d = pick;
`endif
                end
            end
            ST_ACCESS: begin
                state_d = ST_RESP;
                if (grant_q == PORT_D) begin
                    d_ack_d   = 1'b1;
                    d_err_d   = fault_q;
                    d_rdata_d = resp_data;
                end else begin
                    if_ack_d   = 1'b1;
                    if_err_d   = fault_q;
                    if_rdata_d = resp_data;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            grant_q     <= PORT_IF;
            we_q        <= 1'b0;
            fault_q     <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_rd_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            if_ack_q    <= 1'b0;
            d_ack_q     <= 1'b0;
            if_err_q    <= 1'b0;
            d_err_q     <= 1'b0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
`ifdef MEM_ARB_RR_EN
            last_grant_q <= PORT_IF;
`endif
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            we_q        <= we_d;
            fault_q     <= fault_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_rd_q    <= mem_rd_d;
            mem_wr_q    <= mem_wr_d;
            if_ack_q    <= if_ack_d;
            d_ack_q     <= d_ack_d;
            if_err_q    <= if_err_d;
            d_err_q     <= d_err_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
`ifdef MEM_ARB_RR_EN
            last_grant_q <= last_grant_d;
`endif
        end
    end

    assign if_ack    = if_ack_q;
    assign if_err    = if_err_q;
    assign if_rdata  = if_rdata_q;
    assign d_ack     = d_ack_q;
    assign d_err     = d_err_q;
    assign d_rdata   = d_rdata_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_rd    = mem_rd_q;
    assign mem_wr    = mem_wr_q;

endmodule
